// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - AXI3 encodings and the write-DMA state type.
package axi3_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] CACHE_BUFFERABLE  = 4'b0001;
  localparam logic [3:0] CACHE_MODIFIABLE  = 4'b0010;
  localparam logic [3:0] CACHE_READ_ALLOC  = 4'b0100;
  localparam logic [3:0] CACHE_WRITE_ALLOC = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } dma_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO; rdata is the head entry.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hp_write_dma.sv
// rtl/hp_write_dma.sv - AXI3 write-only master: stream words to DRAM in INCR bursts of up to 16 beats.
module hp_write_dma
  import axi3_pkg::*;
#(
  parameter logic [5:0] AXI_ID = 6'd0,
  parameter logic [3:0] CACHE  = 4'b0011,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_base_addr,
  input  logic [23:0] i_length,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  input  logic [31:0] i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_awaddr,
  output logic [3:0]  o_awlen,
  output logic [2:0]  o_awsize,
  output logic [1:0]  o_awburst,
  output logic [1:0]  o_awlock,
  output logic [3:0]  o_awcache,
  output logic [2:0]  o_awprot,
  output logic [3:0]  o_awqos,
  output logic [5:0]  o_awid,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wlast,
  output logic [5:0]  o_wid,
  input  logic        i_bvalid,
  output logic        o_bready,
  input  logic [1:0]  i_bresp,
  input  logic [5:0]  i_bid
);

  dma_state_t  r_state;
  logic [31:0] r_addr;
  logic [23:0] r_remaining;
  logic [23:0] r_to_accept;
  logic [4:0]  r_beats;
  logic [3:0]  r_beat_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_wlast;
  logic        r_bready;

  logic        w_push;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [4:0]  w_fifo_count;
  logic [31:0] w_fifo_rdata;
  logic [4:0]  w_beats;
  logic        w_unused;

  sync_fifo #(.WIDTH(32), .DEPTH(16)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (i_in_data),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // The producer may run ahead of the AXI side but never past the programmed length.
  assign o_in_ready = r_busy && !w_fifo_full && (r_to_accept != '0);
  assign w_push     = i_in_valid && o_in_ready;
  assign w_pop      = r_wvalid && i_wready;
  assign w_beats    = (r_remaining > 24'd16) ? 5'd16 : r_remaining[4:0];
  assign w_unused   = ^{i_bid, w_fifo_empty};

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_error;
  assign o_awvalid = r_awvalid;
  assign o_awaddr  = r_addr;
  assign o_awlen   = 4'(r_beats - 5'd1);
  assign o_awsize  = SIZE_4B;
  assign o_awburst = BURST_INCR;
  assign o_awlock  = 2'b00;
  assign o_awcache = CACHE;
  assign o_awprot  = PROT;
  assign o_awqos   = 4'd0;
  assign o_awid    = AXI_ID;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = w_fifo_rdata;
  assign o_wstrb   = 4'hF;
  assign o_wlast   = r_wlast;
  assign o_wid     = AXI_ID;
  assign o_bready  = r_bready;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_to_accept <= '0;
      r_beats     <= '0;
      r_beat_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) r_to_accept <= r_to_accept - 24'd1;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_length != '0) begin
              r_addr      <= i_base_addr;
              r_remaining <= i_length;
              r_to_accept <= i_length;
              r_error     <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= ST_FILL;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          // A whole burst is buffered before AW so W never starves mid-burst.
          if (w_fifo_count >= w_beats) begin
            r_beats   <= w_beats;
            r_awvalid <= 1'b1;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (i_awready) begin
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b1;
            r_wlast    <= (r_beats == 5'd1);
            r_beat_cnt <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_wready) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= ST_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 4'd1;
              r_wlast    <= (({1'b0, r_beat_cnt} + 5'd2) == r_beats);
            end
          end
        end
        ST_RESP: begin
          if (i_bvalid) begin
            r_bready    <= 1'b0;
            if (i_bresp != RESP_OKAY) r_error <= 1'b1;
            r_remaining <= r_remaining - 24'(r_beats);
            r_addr      <= r_addr + 32'({r_beats, 2'b00});
            if (r_remaining == 24'(r_beats)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hp_write_dma.sv
// tb/tb_hp_write_dma.sv - directed bench for hp_write_dma with a stalling AXI slave and stream producer.
module tb_hp_write_dma;
  import axi3_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [23:0] i_length;
  logic        o_busy, o_done, o_error;
  logic [31:0] i_in_data;
  logic        i_in_valid, o_in_ready;
  logic        o_awvalid, i_awready;
  logic [31:0] o_awaddr;
  logic [3:0]  o_awlen;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst, o_awlock;
  logic [3:0]  o_awcache, o_awqos;
  logic [2:0]  o_awprot;
  logic [5:0]  o_awid, o_wid, i_bid;
  logic        o_wvalid, i_wready, o_wlast;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        i_bvalid, o_bready;
  logic [1:0]  i_bresp;

  always #5 clk = ~clk;

  hp_write_dma dut (
    .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_length(i_length), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
    .o_awsize(o_awsize), .o_awburst(o_awburst), .o_awlock(o_awlock), .o_awcache(o_awcache),
    .o_awprot(o_awprot), .o_awqos(o_awqos), .o_awid(o_awid), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .o_wid(o_wid), .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp), .i_bid(i_bid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave / producer model state
  int unsigned prod_idx = 0, prod_limit = 0;
  logic [31:0] prod_seed = 0;
  bit          stall_en = 0;
  int          err_burst = -1, b_idx = 0, pending_b = 0, in_acc = 0, done_cnt = 0;
  bit          aw_hold = 0, w_hold = 0, b_hold = 0, in_hold = 0;
  logic [31:0] aw_hold_addr, w_hold_data;
  logic [3:0]  aw_hold_len;
  logic [31:0] aw_addr_q[$];
  logic [3:0]  aw_len_q[$];
  logic [31:0] w_data_q[$];
  bit          w_last_q[$];

  initial begin
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = RESP_OKAY; i_bid = 6'd0;
    i_in_valid = 0; i_in_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_in_valid = 0;
        pending_b = 0; aw_hold = 0; w_hold = 0; b_hold = 0; in_hold = 0;
        continue;
      end
      if (o_done) done_cnt++;
      if (aw_hold) begin
        check_eq("aw_stable_valid", 32'(o_awvalid), 32'd1);
        check_eq("aw_stable_addr", o_awaddr, aw_hold_addr);
        check_eq("aw_stable_len", 32'(o_awlen), 32'(aw_hold_len));
      end
      if (w_hold) begin
        check_eq("w_stable_valid", 32'(o_wvalid), 32'd1);
        check_eq("w_stable_data", o_wdata, w_hold_data);
      end
      i_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      i_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!b_hold)
        i_bvalid = (pending_b > 0) && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
      i_bresp = (b_idx == err_burst) ? RESP_SLVERR : RESP_OKAY;
      if (!in_hold) begin
        i_in_valid = (prod_idx < prod_limit) && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
        i_in_data  = prod_seed + prod_idx;
      end
      if (o_awvalid && i_awready) begin
        aw_addr_q.push_back(o_awaddr);
        aw_len_q.push_back(o_awlen);
      end
      aw_hold = o_awvalid && !i_awready;
      aw_hold_addr = o_awaddr; aw_hold_len = o_awlen;
      if (o_wvalid && i_wready) begin
        w_data_q.push_back(o_wdata);
        w_last_q.push_back(o_wlast);
        if (o_wlast) pending_b++;
      end
      w_hold = o_wvalid && !i_wready;
      w_hold_data = o_wdata;
      if (i_bvalid && o_bready) begin
        pending_b--;
        b_idx++;
      end
      b_hold = i_bvalid && !o_bready;
      if (i_in_valid && o_in_ready) begin
        prod_idx++;
        in_acc++;
      end
      in_hold = i_in_valid && !o_in_ready;
    end
  end

  task automatic prep(input logic [31:0] base, input int len, input logic [31:0] seed,
                      input bit stalls, input int errb);
    @(posedge clk); #1;
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
    prod_idx = 0; prod_limit = len + 4; prod_seed = seed; in_hold = 0; i_in_valid = 0;
    stall_en = stalls; err_burst = errb; b_idx = 0; done_cnt = 0; in_acc = 0;
    i_base_addr = base; i_length = 24'(len); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input logic [31:0] seed,
                          input bit stalls, input int errb, input bit poke_start,
                          input logic exp_err);
    int cyc;
    int n;
    prep(base, len, seed, stalls, errb);
    check_eq("start_busy", 32'(o_busy), 32'd1);
    check_eq("start_clears_error", 32'(o_error), 32'd0);
    if (poke_start) begin
      repeat (5) @(posedge clk);
      #1;
      check_eq("poke_busy", 32'(o_busy), 32'd1);
      i_base_addr = 32'hDEAD_0000; i_length = 24'd5; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    n = aw_addr_q.size();
    check_eq("aw_count", 32'(n), 32'((len + 15) / 16));
    for (int k = 0; k < n; k++) begin
      int rem;
      rem = len - 16 * k;
      check_eq("awaddr", aw_addr_q[k], base + 32'(64 * k));
      check_eq("awlen", 32'(aw_len_q[k]), 32'(((rem > 16) ? 16 : rem) - 1));
    end
    n = w_data_q.size();
    check_eq("w_count", 32'(n), 32'(len));
    for (int i = 0; i < n; i++) begin
      check_eq("wdata", w_data_q[i], seed + 32'(i));
      check_eq("wlast", 32'(w_last_q[i]), 32'((i % 16 == 15) || (i == len - 1)));
    end
    check_eq("words_accepted", 32'(in_acc), 32'(len));
    check_eq("in_ready_after", 32'(o_in_ready), 32'd0);
    check_eq("busy_after", 32'(o_busy), 32'd0);
    check_eq("error_after", 32'(o_error), 32'(exp_err));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_length = '0;
    #12;
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_error", 32'(o_error), 32'd0);
    check_eq("rst_in_ready", 32'(o_in_ready), 32'd0);
    check_eq("rst_awvalid", 32'(o_awvalid), 32'd0);
    check_eq("rst_wvalid", 32'(o_wvalid), 32'd0);
    check_eq("rst_wlast", 32'(o_wlast), 32'd0);
    check_eq("rst_bready", 32'(o_bready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    check_eq("const_fields", {o_awsize, o_awburst, o_awlock, o_awqos, o_wstrb},
             {3'b010, 2'b01, 2'b00, 4'h0, 4'hF});
    check_eq("const_axi", {o_awcache, o_awprot, o_awid, o_wid}, {4'b0011, 3'b000, 6'd0, 6'd0});

    run_xfer(32'h1000_0000, 16, 32'h0, 1'b0, -1, 1'b0, 1'b0);
    run_xfer(32'h0000_0040, 20, 32'h100, 1'b0, -1, 1'b0, 1'b0);
    run_xfer(32'h0002_0000, 37, 32'h5500, 1'b1, -1, 1'b0, 1'b0);
    run_xfer(32'h0400_0000, 32, 32'h7700, 1'b0, 1, 1'b1, 1'b1);
    run_xfer(32'h0000_1000, 5, 32'h9900, 1'b0, -1, 1'b0, 1'b0);

    prep(32'h0000_2000, 0, 32'h0, 1'b0, -1);
    check_eq("len0_done", 32'(o_done), 32'd1);
    check_eq("len0_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    check_eq("len0_done_once", 32'(o_done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("len0_no_aw", 32'(aw_addr_q.size()), 32'd0);
    check_eq("len0_awvalid", 32'(o_awvalid), 32'd0);

    prep(32'h2000_0000, 40, 32'hC000, 1'b0, -1);
    cyc = 0;
    while (w_data_q.size() < 4 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_eq("pre_rst_wvalid", 32'(o_wvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_awvalid", 32'(o_awvalid), 32'd0);
    check_eq("mid_rst_wvalid", 32'(o_wvalid), 32'd0);
    check_eq("mid_rst_bready", 32'(o_bready), 32'd0);
    check_eq("mid_rst_in_ready", 32'(o_in_ready), 32'd0);
    check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
    check_eq("mid_rst_wlast", 32'(o_wlast), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    run_xfer(32'h3000_0000, 18, 32'hE000, 1'b0, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hp_write_dma.md
Name: hp_write_dma

Overview:
- AXI3 write-only master for one 32-bit high-performance DRAM port.
- Takes a valid/ready stream of 32-bit words and writes a fixed number of words to DRAM starting at a configured base address, using INCR bursts of up to 16 beats.
- Sits between a pixel/sample producer and the HP port. The read side of the port is handled elsewhere; this block drives only the AW, W and B channels.

Parameters:
- AXI_ID, 6'd0, ID driven on awid and wid; bid is not checked.
- CACHE, 4'b0011, constant awcache (bufferable + modifiable).
- PROT, 3'b000, constant awprot.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; starts a transfer when idle.
- base_addr  in  32  byte address of first word; bits [5:0] must be 0.
- length  in  24  number of 32-bit words to write.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the final B response is received.
- error  out  1  sticky; set when any bresp != OKAY; cleared by the next accepted start.
- in_data  in  32  stream data.
- in_valid  in  1  stream valid.
- in_ready  out  1  stream ready.
- awvalid, awready, awaddr[31:0], awlen[3:0], awsize[2:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0], awqos[3:0], awid[5:0]  AXI3 AW channel.
- wvalid, wready, wdata[31:0], wstrb[3:0], wlast, wid[5:0]  AXI3 W channel.
- bvalid, bready, bresp[1:0], bid[5:0]  AXI3 B channel.

Behaviour:
- Reset values: busy=0, done=0, error=0, in_ready=0, awvalid=0, wvalid=0, wlast=0, bready=0, FIFO empty.
- Reset takes effect asynchronously at any time, including mid-burst. Mid-burst reset is for system reset only; slave-side recovery is out of scope.
- Constant AXI fields:
  - awsize = 3'b010 (4 bytes), awburst = INCR (2'b01), awlock = 0, awqos = 0.
  - wstrb = 4'hF.
  - awid = wid = AXI_ID.
- Latched registers: addr[31:0], remaining[23:0], to_accept[23:0], beats[4:0], beat_cnt[3:0].
- FSM states: IDLE, FILL, ADDR, DATA, RESP.
- IDLE:
  - On start with length != 0: latch addr=base_addr, remaining=to_accept=length, clear error, busy=1, go to FILL.
  - On start with length == 0: done pulses the next cycle; busy stays 0; no AXI traffic.
  - start while not in IDLE is ignored.
- Stream input, in all states except IDLE:
  - in_ready = busy && !fifo_full && to_accept != 0.
  - Each handshake pushes one word into the FIFO and decrements to_accept.
  - Words beyond length are never accepted.
- FILL:
  - beats = min(16, remaining).
  - Move to ADDR when fifo_count >= beats.
- ADDR:
  - awvalid=1, awaddr=addr, awlen=beats-1.
  - On awready, go to DATA.
  - awvalid holds stable until the handshake.
- DATA:
  - wvalid=1 with wdata = FIFO head. The FIFO is guaranteed non-empty here.
  - Pop on wready; beat_cnt increments.
  - wlast=1 exactly on beat beats-1.
  - After the wlast handshake, go to RESP.
- RESP:
  - bready=1.
  - On bvalid: if bresp != 2'b00, set error. Then remaining -= beats and addr += beats*4.
  - If remaining == 0: done=1 for one cycle, busy=0, go to IDLE. Otherwise go to FILL.
- Only one burst is outstanding at a time; AW always precedes W.
- Base alignment to 64 bytes guarantees no burst crosses a 4 KB boundary. Misaligned base_addr is undefined use; no check is made.
- Final partial burst: length % 16 beats, e.g. length 20 gives 16 + 4.
- Stream pushes may overlap ADDR, DATA and RESP. A simultaneous push and pop in DATA leaves the FIFO count unchanged.
- An error response does not abort the transfer; remaining bursts continue.

Decomposition:
- Package axi3_pkg:
  - BURST_FIXED/INCR/WRAP.
  - SIZE_4B.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - CACHE_* bit constants.
  - State enum for this FSM.
- Sub-module sync_fifo:
  - WIDTH=32, DEPTH=16.
  - Ports: push, pop, wdata, rdata, full, empty, count[4:0].
  - Same clock and asynchronous reset as this block.
  - rdata is combinational from the head entry (show-ahead).

Test Plan:
- length=16, base=0x1000_0000, stream 0..15 with awready/wready/bvalid always 1 -> one AW (awaddr=0x1000_0000, awlen=15), 16 beats 0..15, wlast on the 16th beat, done pulse, error=0.
- length=20, base=0x0000_0040 -> AW#1 awaddr=0x40 awlen=15; AW#2 awaddr=0x80 awlen=3; wlast on beats 16 and 20; exactly 20 words accepted; in_ready low afterwards.
- Random stalls on in_valid, awready and wready (~50%), length=37 -> AXI payload order equals stream order, awvalid/wvalid/wdata stable during stalls, three bursts (16, 16, 5).
- Second burst returns bresp=SLVERR, length=32 -> error=1 after the second B; done still pulses; next start clears error.
- start with length=0 -> done pulses next cycle, no awvalid; start pulse while busy -> ignored, transfer completes unchanged.
- Assert reset during DATA beat 5 -> same cycle awvalid=wvalid=bready=in_ready=busy=0; new start after deassertion performs a clean transfer.
